// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the per-core L2 request path.
// Packet layout, source indices and field widths.
package l2_request_arbiter_pkg;

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;
    localparam int REQ_STBUF  = 2;

    localparam int CORE_ID_W = 4;
    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 32;

    typedef logic [CORE_ID_W-1:0] core_id_t;

    typedef enum logic [1:0] {
        UNIT_ICACHE = 2'd0,
        UNIT_DCACHE = 2'd1,
        UNIT_STBUF  = 2'd2
    } unit_id_t;

    typedef enum logic [1:0] {
        L2_LOAD   = 2'd0,
        L2_STORE  = 2'd1,
        L2_IFETCH = 2'd2,
        L2_FLUSH  = 2'd3
    } l2_op_t;

    typedef struct packed {
        logic              valid;
        core_id_t          core;
        unit_id_t          unit;
        l2_op_t            op;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } l2req_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own priority pointer.
// Ports: clk, reset, request (vector), update_lru (grant taken), grant (one-hot).
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant
);

    localparam int N  = NUM_REQUESTERS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   idx;
    logic          found;

    // Scan from the pointer upward, wrapping, first request wins.
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N))
                idx = idx - (PW+1)'(N);
            if (!found && request[idx[PW-1:0]]) begin
                found             = 1'b1;
                win               = idx[PW-1:0];
                grant[idx[PW-1:0]] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win == PW'(N - 1)) ? '0 : win + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (update_lru)
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// Per-core L2 request arbiter: one registered slot toward L2.
// Ports: req_packet/req_grant (sources), l2req_packet/l2req_ready (L2), pc_event_l2_stall.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = 3,
    parameter int CORE_ID        = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  l2req_packet_t             req_packet [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] req_grant,
    input  logic                      l2req_ready,
    output l2req_packet_t             l2req_packet,
    output logic                      pc_event_l2_stall
);

    localparam int N = NUM_REQUESTERS;

    logic          can_load;
    logic          transfer;
    logic [N-1:0]  pending;
    l2req_packet_t win_pkt;
    l2req_packet_t load_pkt;

    assign transfer = l2req_packet.valid && l2req_ready;
    // Slot can take a new packet when empty or draining this cycle.
    assign can_load = !l2req_packet.valid || l2req_ready;

    // Masking here keeps the grant at zero whenever the slot can't load.
    always_comb begin
        pending = '0;
        for (int i = 0; i < N; i++)
            pending[i] = req_packet[i].valid && can_load && !reset;
    end

    rr_arbiter #(
        .NUM_REQUESTERS(N)
    ) u_rr (
        .clk       (clk),
        .reset     (reset),
        .request   (pending),
        .update_lru(|req_grant),
        .grant     (req_grant)
    );

    always_comb begin
        win_pkt = '0;
        for (int i = 0; i < N; i++)
            if (req_grant[i])
                win_pkt = win_pkt | req_packet[i];
    end

    always_comb begin
        load_pkt       = win_pkt;
        load_pkt.core  = core_id_t'(CORE_ID);
        load_pkt.valid = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            l2req_packet <= '0;
        else if (|req_grant)
            l2req_packet <= load_pkt;
        else if (transfer)
            l2req_packet.valid <= 1'b0;
    end

    assign pc_event_l2_stall = l2req_packet.valid && !l2req_ready;

    a_grant_onehot: assert property (
        @(posedge clk) disable iff (reset) $onehot0(req_grant));

    a_no_grant_full: assert property (
        @(posedge clk) disable iff (reset) !can_load |-> req_grant == '0);

    a_slot_hold: assert property (
        @(posedge clk) disable iff (reset)
        pc_event_l2_stall |=> $stable(l2req_packet));

    for (genvar g = 0; g < N; g++) begin : g_src_chk
        a_src_hold: assert property (
            @(posedge clk) disable iff (reset)
            req_packet[g].valid && !req_grant[g] |=> $stable(req_packet[g]));
    end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter.
// Directed scenarios plus a randomized run against a behavioural model.
module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam int N   = 3;
    localparam int CID = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          l2req_ready = 1'b0;
    l2req_packet_t req [N];
    logic [N-1:0]  req_grant;
    l2req_packet_t l2req_packet;
    logic          pc_event_l2_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l2_request_arbiter #(
        .NUM_REQUESTERS(N),
        .CORE_ID       (CID)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_packet       (req),
        .req_grant        (req_grant),
        .l2req_ready      (l2req_ready),
        .l2req_packet     (l2req_packet),
        .pc_event_l2_stall(pc_event_l2_stall)
    );

    function automatic l2req_packet_t mk_pkt(int src, logic [25:0] addr);
        l2req_packet_t p;
        p.valid   = 1'b1;
        p.core    = core_id_t'(4'($urandom_range(0, 15)));
        p.unit    = unit_id_t'(2'(src));
        p.op      = l2_op_t'(2'($urandom_range(0, 3)));
        p.address = addr;
        p.data    = $urandom;
        return p;
    endfunction

    function automatic l2req_packet_t fwd(l2req_packet_t p);
        l2req_packet_t q;
        q       = p;
        q.core  = core_id_t'(CID);
        q.valid = 1'b1;
        return q;
    endfunction

    task automatic clear_reqs();
        for (int i = 0; i < N; i++)
            req[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_reqs();
        l2req_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_reqs();
        req[0] = mk_pkt(0, 26'h0000abc);
        l2req_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (l2req_packet !== '0) begin
            n_fail++;
            $display("FAIL reset_slot got=%h exp=0", l2req_packet);
        end
        n_checks++;
        if (req_grant !== '0) begin
            n_fail++;
            $display("FAIL reset_grant got=%b exp=000", req_grant);
        end
        n_checks++;
        if (pc_event_l2_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall got=%b exp=0", pc_event_l2_stall);
        end
        clear_reqs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single_source();
        l2req_packet_t p;
        do_reset();
        l2req_ready = 1'b1;
        p = mk_pkt(REQ_DCACHE, 26'h0001234);
        req[REQ_DCACHE] = p;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL single_grant got=%b exp=010", req_grant);
        end
        tick();
        req[REQ_DCACHE].valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (l2req_packet.valid !== 1'b1 ||
            l2req_packet.address !== 26'h0001234 ||
            l2req_packet.core !== core_id_t'(CID)) begin
            n_fail++;
            $display("FAIL single_slot got v=%b a=%h c=%h exp v=1 a=0001234 c=%h",
                     l2req_packet.valid, l2req_packet.address,
                     l2req_packet.core, CID);
        end
        n_checks++;
        if (l2req_packet !== fwd(p)) begin
            n_fail++;
            $display("FAIL single_fields got=%h exp=%h", l2req_packet, fwd(p));
        end
        tick();
    endtask

    task automatic test_back_pressure();
        l2req_packet_t pd;
        l2req_packet_t pi;
        do_reset();
        l2req_ready = 1'b0;
        pd = mk_pkt(REQ_DCACHE, 26'h0000777);
        req[REQ_DCACHE] = pd;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_first_grant got=%b exp=010", req_grant);
        end
        tick();
        req[REQ_DCACHE].valid = 1'b0;
        pi = mk_pkt(REQ_ICACHE, 26'h0000555);
        req[REQ_ICACHE] = pi;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_grant !== '0 || pc_event_l2_stall !== 1'b1 ||
                l2req_packet !== fwd(pd)) begin
                n_fail++;
                $display("FAIL bp_stall c=%0d got g=%b s=%b slot=%h exp g=000 s=1 slot=%h",
                         c, req_grant, pc_event_l2_stall, l2req_packet, fwd(pd));
            end
            tick();
        end
        l2req_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b001 || pc_event_l2_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got g=%b s=%b exp g=001 s=0",
                     req_grant, pc_event_l2_stall);
        end
        tick();
        req[REQ_ICACHE].valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (l2req_packet !== fwd(pi)) begin
            n_fail++;
            $display("FAIL bp_next_slot got=%h exp=%h", l2req_packet, fwd(pi));
        end
        tick();
    endtask

    task automatic test_round_robin();
        l2req_packet_t last;
        logic [N-1:0]  exp_g;
        do_reset();
        l2req_ready = 1'b1;
        last = '0;
        for (int i = 0; i < N; i++)
            req[i] = mk_pkt(i, 26'(i + 16));
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_g = N'(1) << (c % N);
            n_checks++;
            if (req_grant !== exp_g) begin
                n_fail++;
                $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_grant, exp_g);
            end
            if (c > 0) begin
                n_checks++;
                if (l2req_packet !== fwd(last)) begin
                    n_fail++;
                    $display("FAIL rr_slot c=%0d got=%h exp=%h",
                             c, l2req_packet, fwd(last));
                end
            end
            last = req[c % N];
            tick();
            req[c % N] = mk_pkt(c % N, 26'($urandom));
        end
    endtask

    task automatic test_pointer_wrap();
        do_reset();
        l2req_ready = 1'b1;
        req[REQ_DCACHE] = mk_pkt(REQ_DCACHE, 26'h0000100);
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL wrap_setup got=%b exp=010", req_grant);
        end
        tick();
        req[REQ_ICACHE] = mk_pkt(REQ_ICACHE, 26'h0000200);
        req[REQ_DCACHE] = mk_pkt(REQ_DCACHE, 26'h0000300);
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_skip got=%b exp=001", req_grant);
        end
        tick();
        req[REQ_ICACHE].valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL wrap_next got=%b exp=010", req_grant);
        end
        tick();
        req[REQ_DCACHE].valid = 1'b0;
    endtask

    task automatic test_transfer_reload();
        l2req_packet_t pi;
        l2req_packet_t ps;
        do_reset();
        l2req_ready = 1'b0;
        pi = mk_pkt(REQ_ICACHE, 26'h0000aaa);
        req[REQ_ICACHE] = pi;
        @(negedge clk);
        tick();
        req[REQ_ICACHE].valid = 1'b0;
        ps = mk_pkt(REQ_STBUF, 26'h0000bbb);
        req[REQ_STBUF] = ps;
        l2req_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b100 || l2req_packet !== fwd(pi)) begin
            n_fail++;
            $display("FAIL xfer_reload got g=%b slot=%h exp g=100 slot=%h",
                     req_grant, l2req_packet, fwd(pi));
        end
        tick();
        req[REQ_STBUF].valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (l2req_packet !== fwd(ps)) begin
            n_fail++;
            $display("FAIL xfer_slot got=%h exp=%h", l2req_packet, fwd(ps));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        l2req_ready = 1'b0;
        req[REQ_DCACHE] = mk_pkt(REQ_DCACHE, 26'h0000ccc);
        @(negedge clk);
        tick();
        req[REQ_DCACHE].valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_event_l2_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_stall got=%b exp=1", pc_event_l2_stall);
        end
        reset = 1'b1;
        req[REQ_DCACHE] = mk_pkt(REQ_DCACHE, 26'h0000d01);
        req[REQ_STBUF]  = mk_pkt(REQ_STBUF, 26'h0000d02);
        #1;
        n_checks++;
        if (l2req_packet.valid !== 1'b0 || req_grant !== '0) begin
            n_fail++;
            $display("FAIL mid_async got v=%b g=%b exp v=0 g=000",
                     l2req_packet.valid, req_grant);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_grant !== 3'b010) begin
            n_fail++;
            $display("FAIL mid_after got=%b exp=010", req_grant);
        end
        tick();
        clear_reqs();
    endtask

    task automatic test_random();
        l2req_packet_t m_slot;
        int            m_ptr;
        int            w;
        int            j;
        logic          can_ld;
        logic          exp_stall;
        logic [N-1:0]  exp_g;
        do_reset();
        m_slot = '0;
        m_ptr  = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            l2req_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if (!req[i].valid && $urandom_range(0, 2) != 0)
                    req[i] = mk_pkt(i, 26'($urandom));
            @(negedge clk);
            can_ld = !m_slot.valid || l2req_ready;
            w = -1;
            if (can_ld)
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (w < 0 && req[j].valid)
                        w = j;
                end
            exp_g = (w >= 0) ? (N'(1) << w) : '0;
            exp_stall = m_slot.valid && !l2req_ready;
            n_checks++;
            if (req_grant !== exp_g) begin
                n_fail++;
                $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_grant, exp_g);
            end
            n_checks++;
            if (pc_event_l2_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL rand_stall cyc=%0d got=%b exp=%b",
                         cyc, pc_event_l2_stall, exp_stall);
            end
            n_checks++;
            if (l2req_packet.valid !== m_slot.valid) begin
                n_fail++;
                $display("FAIL rand_valid cyc=%0d got=%b exp=%b",
                         cyc, l2req_packet.valid, m_slot.valid);
            end
            if (m_slot.valid) begin
                n_checks++;
                if (l2req_packet !== m_slot) begin
                    n_fail++;
                    $display("FAIL rand_slot cyc=%0d got=%h exp=%h",
                             cyc, l2req_packet, m_slot);
                end
            end
            @(posedge clk);
            if (w >= 0) begin
                m_slot = fwd(req[w]);
                m_ptr  = (w + 1) % N;
            end else if (m_slot.valid && l2req_ready) begin
                m_slot.valid = 1'b0;
            end
            #1;
            if (w >= 0)
                req[w].valid = 1'b0;
        end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_single_source();
        test_back_pressure();
        test_round_robin();
        test_pointer_wrap();
        test_transfer_reload();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Per-core arbiter directly downstream of the L1 instruction cache, L1 data cache and store buffer request outputs.
- Selects one pending L2 request per cycle, round-robin, and holds it in a registered output slot.
- Drives the core's single l2req_packet / l2req_ready interface toward the L2 cache.
- Stamps the core id on each packet; grants back-pressure to the requesters when the slot is occupied.

Parameters:
- NUM_REQUESTERS, 3, number of request sources; index 0 = icache, 1 = dcache, 2 = store buffer.
- CORE_ID, 0, value written into the core field of every forwarded packet.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- req_packet, input, l2req_packet_t[NUM_REQUESTERS], candidate request per source; pending when .valid=1.
- req_grant, output, NUM_REQUESTERS, one-hot; source i's packet is captured this cycle.
- l2req_ready, input, 1, L2 accepts the presented packet this cycle.
- l2req_packet, output, l2req_packet_t, registered request to L2.
- pc_event_l2_stall, output, 1, high for each cycle the slot holds a valid packet with l2req_ready=0.

Behaviour:
- Reset:
  - l2req_packet.valid=0, remaining packet fields 0.
  - req_grant=0, pc_event_l2_stall=0.
  - Priority pointer=0.
- Slot state: EMPTY (valid=0) / FULL (valid=1). These are the only two states.
- Transfer to L2 occurs when l2req_packet.valid && l2req_ready.
- can_load = !l2req_packet.valid || l2req_ready. A transfer and a reload may happen in the same cycle, giving full throughput of one packet per cycle.
- Arbitration (combinational):
  - Among sources with req_packet[i].valid, pick the first at or after the pointer, wrapping modulo NUM_REQUESTERS.
  - req_grant[i]=1 only for the winner and only when can_load=1; otherwise req_grant=0.
  - Grant depends on l2req_ready in the same cycle (combinational path, accepted).
- On grant, at the next edge:
  - Slot <= winner packet, with core field forced to CORE_ID and valid=1.
  - Pointer <= winner+1, wrapping modulo NUM_REQUESTERS (e.g. 2 -> 0).
- No grant and transfer: slot valid <= 0. Data fields may retain stale values.
- No grant, no transfer: slot holds every field stable (L2 protocol requirement).
- Pointer changes only on a grant.
- Requester rules:
  - A source keeps its packet valid and unchanged until granted. Violation = assertion failure.
  - In the cycle after a grant the source may present a new packet. It then re-arbitrates behind the other sources.
- Latency: request at cycle N with the slot free -> grant at N -> l2req_packet.valid at N+1.
- Fairness: with all sources continuously requesting, each source gets exactly 1 grant in any NUM_REQUESTERS consecutive grants.
- pc_event_l2_stall = l2req_packet.valid && !l2req_ready, combinational from the registered slot.
- Reset mid-operation: the pending slot packet is discarded and the pointer returns to 0. Requesters are reset by the same signal.
- Assertions:
  - req_grant is one-hot or zero.
  - Never grant when !can_load.
  - Slot fields are stable while FULL and !l2req_ready.

Decomposition:
- l2req_packet_t, unit_id_t, and the source index constants (REQ_ICACHE=0, REQ_DCACHE=1, REQ_STBUF=2) belong in the shared defines/package.
- One natural sub-module: rr_arbiter, parameterised on NUM_REQUESTERS. Inputs: request vector, update_lru (grant taken). Output: one-hot grant. It owns the pointer flop and is reusable by the L2 core arbiter.
- The slot register and can_load logic stay in the top module.

Test Plan:
- Single source: dcache presents address 26'h0001234 with the slot EMPTY and l2req_ready=1 -> req_grant=3'b010 the same cycle; next cycle l2req_packet.valid=1, address=26'h0001234, core=CORE_ID.
- Back-pressure: slot FULL, l2req_ready=0 for 5 cycles while icache requests -> req_grant=0, slot fields unchanged, pc_event_l2_stall=1 for 5 cycles; ready=1 -> icache granted the same cycle.
- Round-robin: all 3 sources request continuously with l2req_ready=1 -> grant sequence 001, 010, 100, 001, ...; one packet forwarded per cycle with no bubbles.
- Pointer wrap / skip: pointer=2 with only sources 0 and 1 pending -> source 0 granted, pointer becomes 1, then source 1 granted.
- Simultaneous transfer and reload: slot FULL with an icache packet, l2req_ready=1 and the store buffer pending -> store buffer granted the same cycle; next cycle the slot holds the store packet with valid continuously 1.
- Reset mid-operation: slot FULL and stalled, assert reset -> l2req_packet.valid=0 and req_grant=0 immediately (asynchronous); after release with sources 1 and 2 pending, source 1 is granted first (pointer=0).
